// File: rtl/pb_cmd_decoder.sv
// Two-button command decoder: synchronize, debounce, turn debounced presses into SLOW/FAST commands
// behind a valid/ack handshake. Define LONG_PRESS_EN to also issue STOP on a long hold.
module pb_cmd_decoder #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int LONG_CYCLES     = 100000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       PB1,
    input  logic       PB2,
    output logic [1:0] cmd,
    output logic       cmd_valid,
    input  logic       cmd_ack,
    output logic [1:0] mode,
    output logic       overrun
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] CMD_SLOW = 2'b01;
    localparam logic [1:0] CMD_FAST = 2'b10;
    localparam logic [1:0] CMD_STOP = 2'b11;

    if (DEBOUNCE_CYCLES < 1 || LONG_CYCLES < 1) begin : g_bad_params
        $error("pb_cmd_decoder: DEBOUNCE_CYCLES and LONG_CYCLES must be >= 1");
    end

    logic [1:0] w_pb;
    logic [1:0] w_press;
    logic [1:0] w_stop;
    logic       w_settled;
    logic       w_evt;
    logic [1:0] w_code;

    logic [1:0] r_settle;
    logic [1:0] r_cmd;
    logic       r_cmd_valid;
    logic [1:0] r_mode;
    logic       r_overrun;

    assign w_pb      = {PB2, PB1};
    assign w_settled = r_settle[1];

    // The synchronizer only holds a real button sample two edges after reset; arming waits for that.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_settle <= 2'd0;
        end else if (!r_settle[1]) begin
            r_settle <= r_settle + 2'd1;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
        logic            r_sync1;
        logic            r_sync2;
        logic            r_db;
        logic            r_db_d1;
        logic            r_armed;
        logic [DB_W-1:0] r_db_cnt;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_sync1  <= 1'b1;
                r_sync2  <= 1'b1;
                r_db     <= 1'b1;
                r_db_d1  <= 1'b1;
                r_armed  <= 1'b0;
                r_db_cnt <= '0;
            end else begin
                r_sync1 <= w_pb[gi];
                r_sync2 <= r_sync1;
                r_db_d1 <= r_db;
                if (r_sync2 == r_db) begin
                    r_db_cnt <= '0;
                end else if (r_db_cnt == DB_LAST) begin
                    r_db     <= r_sync2;
                    r_db_cnt <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + 1'b1;
                end
                // A button held through reset stays disarmed until it is seen released.
                if (w_settled && r_sync2) begin
                    r_armed <= 1'b1;
                end
            end
        end

        assign w_press[gi] = r_armed & r_db_d1 & ~r_db;

`ifdef LONG_PRESS_EN
        localparam int HL_W = $clog2(LONG_CYCLES + 1);
        localparam logic [HL_W-1:0] HOLD_MAX  = HL_W'(LONG_CYCLES);
        localparam logic [HL_W-1:0] HOLD_LAST = HL_W'(LONG_CYCLES - 1);

        logic [HL_W-1:0] r_hold;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_hold <= '0;
            end else if (r_db) begin
                r_hold <= '0;
            end else if (r_hold != HOLD_MAX) begin
                r_hold <= r_hold + 1'b1;
            end
        end

        // Fires on the single edge the saturating counter reaches its limit.
        assign w_stop[gi] = r_armed & ~r_db & (r_hold == HOLD_LAST);
`else
        assign w_stop[gi] = 1'b0;
`endif
    end

    always_comb begin
        w_evt  = 1'b0;
        w_code = 2'b00;
        if (w_press[0]) begin
            w_evt  = 1'b1;
            w_code = CMD_SLOW;
        end else if (w_press[1]) begin
            w_evt  = 1'b1;
            w_code = CMD_FAST;
        end else if (w_stop[0] || w_stop[1]) begin
            w_evt  = 1'b1;
            w_code = CMD_STOP;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cmd       <= 2'b00;
            r_cmd_valid <= 1'b0;
            r_mode      <= 2'b00;
            r_overrun   <= 1'b0;
        end else if (w_evt) begin
            r_cmd       <= w_code;
            r_mode      <= w_code;
            r_cmd_valid <= 1'b1;
            if (r_cmd_valid && !cmd_ack) begin
                r_overrun <= 1'b1;
            end
        end else if (r_cmd_valid && cmd_ack) begin
            r_cmd_valid <= 1'b0;
        end
    end

    assign cmd       = r_cmd;
    assign cmd_valid = r_cmd_valid;
    assign mode      = r_mode;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_pb_cmd_decoder.sv
// Directed bench for pb_cmd_decoder with DEBOUNCE_CYCLES=4, LONG_CYCLES=20.
module tb_pb_cmd_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       PB1;
    logic       PB2;
    logic       cmd_ack;
    logic [1:0] cmd;
    logic       cmd_valid;
    logic [1:0] mode;
    logic       overrun;

    int checks   = 0;
    int failures = 0;
    int n_valid;
    int n_stop;

    pb_cmd_decoder #(
        .DEBOUNCE_CYCLES(4),
        .LONG_CYCLES    (20)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .PB1      (PB1),
        .PB2      (PB2),
        .cmd      (cmd),
        .cmd_valid(cmd_valid),
        .cmd_ack  (cmd_ack),
        .mode     (mode),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
        $display("check %-22s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    initial begin
        rst = 1'b0; PB1 = 1'b1; PB2 = 1'b1; cmd_ack = 1'b1;
        step(3);
        check("rst_cmd", cmd, 0);
        check("rst_valid", cmd_valid, 0);
        check("rst_mode", mode, 0);
        check("rst_overrun", overrun, 0);
        rst = 1'b1;
        step(5);

        // PB1 press with ack tied high: valid for exactly one cycle at edge 7.
        PB1 = 1'b0;
        step(6);
        check("slow_edge6_valid", cmd_valid, 0);
        step(1);
        check("slow_edge7_valid", cmd_valid, 1);
        check("slow_edge7_cmd", cmd, 1);
        check("slow_edge7_mode", mode, 1);
        step(1);
        check("slow_edge8_valid", cmd_valid, 0);
        PB1 = 1'b1;
        n_valid = 0;
        for (int i = 0; i < 10; i++) begin step(1); if (cmd_valid) n_valid++; end
        check("release_no_cmd", n_valid, 0);

        // Three-cycle glitch on PB2.
        PB2 = 1'b0;
        step(3);
        PB2 = 1'b1;
        n_valid = 0;
        for (int i = 0; i < 12; i++) begin step(1); if (cmd_valid) n_valid++; end
        check("glitch_no_cmd", n_valid, 0);
        check("glitch_mode", mode, 1);

        // Simultaneous press: SLOW only.
        PB1 = 1'b0; PB2 = 1'b0;
        step(7);
        check("both_valid", cmd_valid, 1);
        check("both_cmd", cmd, 1);
        n_valid = 0;
        for (int i = 0; i < 6; i++) begin step(1); if (cmd_valid) n_valid++; end
        check("both_no_fast", n_valid, 0);
        check("both_mode", mode, 1);
        PB1 = 1'b1; PB2 = 1'b1;
        step(10);

        // Overwrite while unacknowledged.
        cmd_ack = 1'b0;
        PB1 = 1'b0;
        step(7);
        check("ovr_slow_valid", cmd_valid, 1);
        check("ovr_slow_cmd", cmd, 1);
        check("ovr_pre_overrun", overrun, 0);
        step(2);
        check("ovr_hold_valid", cmd_valid, 1);
        PB2 = 1'b0;
        step(7);
        check("ovr_fast_cmd", cmd, 2);
        check("ovr_fast_valid", cmd_valid, 1);
        check("ovr_overrun", overrun, 1);
        check("ovr_mode", mode, 2);
        cmd_ack = 1'b1;
        step(1);
        check("ovr_ack_clears", cmd_valid, 0);
        step(1);
        check("ovr_ack_idle", cmd_valid, 0);
        cmd_ack = 1'b0;
        step(1);
        check("ovr_sticky", overrun, 1);
        PB1 = 1'b1; PB2 = 1'b1;
        step(10);

        // Long hold on PB2 for 40 cycles.
        cmd_ack = 1'b1;
        PB2 = 1'b0;
        step(7);
        check("long_fast_valid", cmd_valid, 1);
        check("long_fast_cmd", cmd, 2);
        n_stop = 0;
        n_valid = 0;
        for (int i = 0; i < 33; i++) begin
            step(1);
            if (cmd_valid) n_valid++;
            if (cmd_valid && cmd == 2'b11) n_stop++;
        end
`ifdef LONG_PRESS_EN
        check("long_stop_count", n_stop, 1);
        check("long_extra_valid", n_valid, 1);
        check("long_mode", mode, 3);
`else
        check("long_stop_count", n_stop, 0);
        check("long_extra_valid", n_valid, 0);
        check("long_mode", mode, 2);
`endif
        PB2 = 1'b1;
        step(10);

        // Reset in the middle of a PB1 debounce, PB1 held through deassertion.
        PB1 = 1'b0;
        step(5);
        rst = 1'b0;
        step(2);
        check("mid_rst_cmd", cmd, 0);
        check("mid_rst_valid", cmd_valid, 0);
        check("mid_rst_mode", mode, 0);
        check("mid_rst_overrun", overrun, 0);
        rst = 1'b1;
        n_valid = 0;
        for (int i = 0; i < 20; i++) begin step(1); if (cmd_valid) n_valid++; end
        check("held_no_cmd", n_valid, 0);
        check("held_mode", mode, 0);
        PB1 = 1'b1;
        n_valid = 0;
        for (int i = 0; i < 10; i++) begin step(1); if (cmd_valid) n_valid++; end
        check("held_release_no_cmd", n_valid, 0);
        PB1 = 1'b0;
        step(7);
        check("repress_valid", cmd_valid, 1);
        check("repress_cmd", cmd, 1);
        check("repress_mode", mode, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
